// File: rtl/register_bus_pkg.sv
// rtl/register_bus_pkg.sv - shared definitions for the register-bank toggle bus
package register_bus_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int IDX_W_DEF  = 3;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ2 = 2'b01;
  localparam logic [1:0] OP_READ1 = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FIRE,
    WR_HOLD,
    WAIT_RSP,
    DONE_ST
  } state_t;

endpackage

// File: rtl/toggle_sync.sv
// rtl/toggle_sync.sv - synchroniser chain for an asynchronous toggle plus event detect
module toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic toggle_in,
  output logic toggle_evt
);

  logic [STAGES-1:0] chain;
  logic              last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      last  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], toggle_in};
      last  <= chain[STAGES-1];
    end
  end

  // last follows the synchronised level, so it moves on every event
  assign toggle_evt = chain[STAGES-1] != last;

endmodule

// File: rtl/register_requester.sv
// rtl/register_requester.sv - initiator for the register-bank toggle protocol
module register_requester
  import register_bus_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int IDX_W       = IDX_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 15,
  parameter int WR_SETTLE   = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [1:0]        REQ_OP,
  input  logic [IDX_W-1:0]  REQ_INDEX_A,
  input  logic [IDX_W-1:0]  REQ_INDEX_B,
  input  logic [DATA_W-1:0] REQ_DATA,
  output logic              LI_CONTROLER,
  output logic [1:0]        OPERATION,
  output logic [IDX_W-1:0]  INDEX_0,
  output logic [IDX_W-1:0]  INDEX_1,
  output logic [DATA_W-1:0] DATA_IN,
  input  logic              RESPONSE,
  input  logic [DATA_W-1:0] DATA_OUT_0,
  input  logic [DATA_W-1:0] DATA_OUT_1,
  output logic              DONE,
  output logic              ERR,
  output logic [DATA_W-1:0] RD_DATA_A,
  output logic [DATA_W-1:0] RD_DATA_B,
  output logic              TIMEOUT_FLAG,
  output logic              STRAY_FLAG
);

  localparam int CNT_MAX = (TIMEOUT > WR_SETTLE) ? TIMEOUT : WR_SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_SETTLE - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic             rsp_evt;
  logic             timed_out;

  toggle_sync #(.STAGES(SYNC_STAGES)) u_rsp_sync (
    .clk        (CLK),
    .rst        (RESET),
    .toggle_in  (RESPONSE),
    .toggle_evt (rsp_evt)
  );

  assign REQ_READY = (state == IDLE);
  assign timed_out = (state == WAIT_RSP) && !rsp_evt && (cnt == TO_LAST);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (REQ_VALID) next_state = (REQ_OP == OP_NOP) ? DONE_ST : SETUP;
      SETUP:    next_state = FIRE;
      FIRE: begin
        case (OPERATION)
          OP_WRITE:           next_state = WR_HOLD;
          OP_READ2, OP_READ1: next_state = WAIT_RSP;
          default:            next_state = DONE_ST;
        endcase
      end
      WR_HOLD:  if (cnt == WR_LAST) next_state = DONE_ST;
      WAIT_RSP: if (rsp_evt || timed_out) next_state = DONE_ST;
      DONE_ST:  next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      cnt          <= '0;
      LI_CONTROLER <= 1'b0;
      OPERATION    <= OP_NOP;
      INDEX_0      <= '0;
      INDEX_1      <= '0;
      DATA_IN      <= '0;
      DONE         <= 1'b0;
      ERR          <= 1'b0;
      RD_DATA_A    <= '0;
      RD_DATA_B    <= '0;
      TIMEOUT_FLAG <= 1'b0;
      STRAY_FLAG   <= 1'b0;
    end else begin
      state <= next_state;
      DONE  <= (next_state == DONE_ST);
      ERR   <= (next_state == DONE_ST) && ((state == IDLE) || timed_out);

      if (state == WR_HOLD || state == WAIT_RSP) cnt <= cnt + 1'b1;
      else                                       cnt <= '0;

      // bus is loaded at accept so it is stable through SETUP, ahead of the toggle
      if (state == IDLE && next_state == SETUP) begin
        OPERATION <= REQ_OP;
        INDEX_0   <= REQ_INDEX_A;
        INDEX_1   <= REQ_INDEX_B;
        DATA_IN   <= REQ_DATA;
      end else if (next_state == DONE_ST) begin
        OPERATION <= OP_NOP;
      end

      if (state == SETUP) LI_CONTROLER <= ~LI_CONTROLER;

      if (state == WAIT_RSP && rsp_evt) begin
        RD_DATA_A <= DATA_OUT_0;
        RD_DATA_B <= (OPERATION == OP_READ2) ? DATA_OUT_1 : '0;
      end

      if (timed_out)                     TIMEOUT_FLAG <= 1'b1;
      if (rsp_evt && state != WAIT_RSP)  STRAY_FLAG   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_register_requester.sv
// tb/tb_register_requester.sv - scoreboard bench for register_requester with a bank model
module tb_register_requester;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic [1:0] REQ_OP = 2'b11;
  logic [2:0] REQ_INDEX_A = '0;
  logic [2:0] REQ_INDEX_B = '0;
  logic [7:0] REQ_DATA = '0;
  logic       LI_CONTROLER;
  logic [1:0] OPERATION;
  logic [2:0] INDEX_0, INDEX_1;
  logic [7:0] DATA_IN;
  logic       RESPONSE;
  logic [7:0] DATA_OUT_0, DATA_OUT_1;
  logic       DONE, ERR;
  logic [7:0] RD_DATA_A, RD_DATA_B;
  logic       TIMEOUT_FLAG, STRAY_FLAG;

  register_requester dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_INDEX_A(REQ_INDEX_A), .REQ_INDEX_B(REQ_INDEX_B), .REQ_DATA(REQ_DATA),
    .LI_CONTROLER(LI_CONTROLER), .OPERATION(OPERATION),
    .INDEX_0(INDEX_0), .INDEX_1(INDEX_1), .DATA_IN(DATA_IN),
    .RESPONSE(RESPONSE), .DATA_OUT_0(DATA_OUT_0), .DATA_OUT_1(DATA_OUT_1),
    .DONE(DONE), .ERR(ERR), .RD_DATA_A(RD_DATA_A), .RD_DATA_B(RD_DATA_B),
    .TIMEOUT_FLAG(TIMEOUT_FLAG), .STRAY_FLAG(STRAY_FLAG)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // bank model: answers a read in the same cycle the toggle arrives
  logic [7:0] mem [8];
  logic       li_seen, resp_q;
  logic       stray_tog = 1'b0;
  logic       respond_en = 1'b1;
  wire        pending = LI_CONTROLER != li_seen;
  wire        is_rd = (OPERATION == 2'b01) || (OPERATION == 2'b10);

  assign RESPONSE   = resp_q ^ stray_tog ^ (pending && is_rd && respond_en);
  assign DATA_OUT_0 = mem[INDEX_0];
  assign DATA_OUT_1 = mem[INDEX_1];

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      li_seen <= 1'b0;
      resp_q  <= 1'b0;
    end else if (pending) begin
      li_seen <= LI_CONTROLER;
      if (is_rd && respond_en) resp_q <= ~resp_q;
    end
  end

  always @(posedge CLK) begin
    if (!RESET && pending && OPERATION == 2'b00) mem[INDEX_0] <= DATA_IN;
  end

  typedef struct { int acc; int lat; logic err; logic [7:0] a; logic [7:0] b; logic tf; logic sf; } exp_t;
  typedef struct { logic [1:0] op; logic [2:0] i0; logic [2:0] i1; logic [7:0] d; } tog_t;
  exp_t sb[$];
  tog_t tq[$];

  logic        li_d = 1'b0;
  logic        rst_d = 1'b1;
  logic [15:0] bus_d = '0;
  exp_t        e;
  tog_t        t;

  // monitor: DONE completions and bank toggles are checked against the queues
  always @(negedge CLK) begin
    if (!RESET && DONE) begin
      if (sb.size() == 0) chk("unexpected_done", {31'd0, DONE}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("latency", cyc - e.acc, e.lat);
        chk("err", {31'd0, ERR}, {31'd0, e.err});
        chk("rd_data_a", {24'd0, RD_DATA_A}, {24'd0, e.a});
        chk("rd_data_b", {24'd0, RD_DATA_B}, {24'd0, e.b});
        chk("timeout_flag", {31'd0, TIMEOUT_FLAG}, {31'd0, e.tf});
        chk("stray_flag", {31'd0, STRAY_FLAG}, {31'd0, e.sf});
      end
    end
    if (!RESET && !rst_d && LI_CONTROLER !== li_d) begin
      if (tq.size() == 0) chk("unexpected_toggle", {31'd0, LI_CONTROLER}, {31'd0, li_d});
      else begin
        t = tq.pop_front();
        chk("toggle_bus", {16'd0, OPERATION, INDEX_0, INDEX_1, DATA_IN}, {16'd0, t.op, t.i0, t.i1, t.d});
        chk("bus_stable_before_toggle", {16'd0, bus_d}, {16'd0, t.op, t.i0, t.i1, t.d});
      end
    end
    li_d  <= LI_CONTROLER;
    rst_d <= RESET;
    bus_d <= {OPERATION, INDEX_0, INDEX_1, DATA_IN};
  end

  task automatic issue(input logic [1:0] op, input logic [2:0] ia, input logic [2:0] ib,
                       input logic [7:0] d, input int lat, input logic err,
                       input logic [7:0] ea, input logic [7:0] eb,
                       input logic tf, input logic sf, input bit track);
    int n = 0;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_OP = op; REQ_INDEX_A = ia; REQ_INDEX_B = ib; REQ_DATA = d;
    while (!REQ_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("req_ready_at_accept", {31'd0, REQ_READY}, 32'd1);
    if (track) sb.push_back('{cyc, lat, err, ea, eb, tf, sf});
    if (op != 2'b11) tq.push_back('{op, ia, ib, d});
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    chk("done_within_budget", sb.size(), 32'd0);
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", {31'd0, REQ_READY}, 32'd1);
    chk("rst_li", {31'd0, LI_CONTROLER}, 32'd0);
    chk("rst_operation", {30'd0, OPERATION}, 32'd3);
    chk("rst_indexes", {26'd0, INDEX_0, INDEX_1}, 32'd0);
    chk("rst_data_in", {24'd0, DATA_IN}, 32'd0);
    chk("rst_done_err", {30'd0, DONE, ERR}, 32'd0);
    chk("rst_rd_data", {16'd0, RD_DATA_A, RD_DATA_B}, 32'd0);
    chk("rst_flags", {30'd0, TIMEOUT_FLAG, STRAY_FLAG}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check_reset_vals();
    RESET = 1'b0;

    issue(2'b00, 3'd3, 3'd0, 8'hA5, 5, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(2'b00, 3'd5, 3'd1, 8'h3C, 5, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(2'b01, 3'd3, 3'd5, 8'h00, 5, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(2'b10, 3'd5, 3'd3, 8'h00, 5, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_done();

    respond_en = 1'b0;
    issue(2'b01, 3'd3, 3'd5, 8'h00, 18, 1'b1, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_done();
    stray_tog = 1'b1;
    repeat (5) @(negedge CLK);
    chk("stray_after_timeout", {31'd0, STRAY_FLAG}, 32'd1);

    issue(2'b11, 3'd1, 3'd2, 8'h77, 1, 1'b1, 8'h3C, 8'h00, 1'b1, 1'b1, 1'b1);
    wait_done();

    issue(2'b01, 3'd3, 3'd5, 8'h00, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    #2;
    RESET = 1'b1;
    stray_tog = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    respond_en = 1'b1;

    issue(2'b01, 3'd3, 3'd5, 8'h00, 5, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_done();
    repeat (3) @(negedge CLK);
    chk("toggles_all_seen", tq.size(), 32'd0);
    chk("no_pending_done", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
